// File: rtl/proc_switch_ctrl.sv
// Context-switch controller: owns the process table, admits new processes and
// sequences halt -> save -> round-robin select -> load for every switch.
module proc_switch_ctrl #(
    parameter int NPROC = 8,
    parameter int PIDW  = 3,
    parameter int PCW   = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            preempt,
    input  logic            exit_req,
    input  logic            create_valid,
    input  logic [PCW-1:0]  create_pc,
    output logic            create_ready,
    output logic            cpu_halt_req,
    input  logic            cpu_halted,
    input  logic [PCW-1:0]  cpu_pc,
    output logic            load_pc_valid,
    output logic [PCW-1:0]  load_pc,
    output logic [PIDW-1:0] cur_pid,
    output logic [PIDW:0]   nprocs,
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        HALT_WAIT = 3'd2,
        SAVE      = 3'd3,
        SELECT    = 3'd4,
        LOAD      = 3'd5
    } state_t;

    localparam logic [PIDW:0] NPROC_CNT = (PIDW+1)'(NPROC);
    localparam logic [PIDW:0] CNT_ONE   = 1;

    state_t          state, state_next;
    logic [NPROC-1:0] proc_valid;
    logic [PCW-1:0]  pc_tab [NPROC];
    logic            exiting;
    logic            create_fire;
    logic [PIDW-1:0] free_idx;
    logic [PIDW-1:0] cand;
    logic [PIDW-1:0] sel_idx;
    logic            sel_found;
    logic [PIDW:0]   nprocs_next;

    assign dbg_state   = state;
    assign create_fire = create_valid && create_ready;

    // Lowest-index free slot for an incoming create.
    always_comb begin
        free_idx = '0;
        for (int i = NPROC - 1; i >= 0; i--) begin
            if (!proc_valid[i]) free_idx = PIDW'(i);
        end
    end

    // Round-robin scan: offsets NPROC..1 walked downwards so the smallest
    // offset after cur_pid wins; offset NPROC wraps to cur_pid itself.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = cur_pid;
        cand      = cur_pid;
        for (int i = NPROC; i >= 1; i--) begin
            cand = cur_pid + PIDW'(i);
            if (proc_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (create_fire) state_next = SELECT;
            RUN:       if (exit_req || preempt) state_next = HALT_WAIT;
            HALT_WAIT: if (cpu_halted) state_next = SAVE;
            SAVE:      state_next = SELECT;
            SELECT:    state_next = sel_found ? LOAD : IDLE;
            LOAD:      state_next = RUN;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        nprocs_next = nprocs;
        if (state == SAVE && exiting && proc_valid[cur_pid] && nprocs != '0)
            nprocs_next = nprocs - CNT_ONE;
        else if (create_fire)
            nprocs_next = nprocs + CNT_ONE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            proc_valid    <= '0;
            for (int i = 0; i < NPROC; i++) pc_tab[i] <= '0;
            exiting       <= 1'b0;
            cur_pid       <= '0;
            nprocs        <= '0;
            cpu_halt_req  <= 1'b1;
            load_pc_valid <= 1'b0;
            load_pc       <= '0;
            create_ready  <= 1'b1;
        end else begin
            state         <= state_next;
            nprocs        <= nprocs_next;
            cpu_halt_req  <= (state_next != RUN);
            load_pc_valid <= (state_next == LOAD);
            create_ready  <= (nprocs_next < NPROC_CNT) && (state_next != SAVE);

            // create_ready is low in SAVE, so this never collides with the save write.
            if (create_fire) begin
                proc_valid[free_idx] <= 1'b1;
                pc_tab[free_idx]     <= create_pc;
            end

            case (state)
                RUN, HALT_WAIT: if (exit_req) exiting <= 1'b1;
                SAVE: begin
                    if (exiting) begin
                        proc_valid[cur_pid] <= 1'b0;
                        exiting             <= 1'b0;
                    end else begin
                        pc_tab[cur_pid] <= cpu_pc;
                    end
                end
                SELECT: begin
                    if (sel_found) begin
                        cur_pid <= sel_idx;
                        load_pc <= pc_tab[sel_idx];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_switch_ctrl.sv
// Bench for proc_switch_ctrl: a process-table model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_proc_switch_ctrl;
    localparam int NPROC = 8;
    localparam int PIDW  = 3;
    localparam int PCW   = 32;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            preempt = 1'b0;
    logic            exit_req = 1'b0;
    logic            create_valid = 1'b0;
    logic [PCW-1:0]  create_pc = '0;
    logic            create_ready;
    logic            cpu_halt_req;
    logic            cpu_halted = 1'b1;
    logic [PCW-1:0]  cpu_pc = '0;
    logic            load_pc_valid;
    logic [PCW-1:0]  load_pc;
    logic [PIDW-1:0] cur_pid;
    logic [PIDW:0]   nprocs;
    logic [2:0]      dbg_state;

    proc_switch_ctrl #(.NPROC(NPROC), .PIDW(PIDW), .PCW(PCW)) dut (
        .clock(clock), .reset(reset), .preempt(preempt), .exit_req(exit_req),
        .create_valid(create_valid), .create_pc(create_pc), .create_ready(create_ready),
        .cpu_halt_req(cpu_halt_req), .cpu_halted(cpu_halted), .cpu_pc(cpu_pc),
        .load_pc_valid(load_pc_valid), .load_pc(load_pc), .cur_pid(cur_pid),
        .nprocs(nprocs), .dbg_state(dbg_state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    bit check_en = 1'b0;

    // Model: mode 0 idle, 1 running, 2 waiting for halt, 3 switching
    // (step 0 save, 1 select, 2 load).
    int         m_mode, m_step, m_cur, m_n;
    bit         m_exit;
    bit         m_valid [NPROC];
    logic [PCW-1:0] m_pc [NPROC];
    logic [PCW-1:0] m_lpc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_cr();
        return (m_n < NPROC) && !(m_mode == 3 && m_step == 0);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_step = 0; m_cur = 0; m_n = 0; m_exit = 0; m_lpc = '0;
        for (int i = 0; i < NPROC; i++) begin m_valid[i] = 0; m_pc[i] = '0; end
    endtask

    task automatic model_step();
        bit acc, found;
        int idx;
        acc = create_valid && exp_cr();
        case (m_mode)
            0: if (acc) begin m_mode = 3; m_step = 1; end
            1: if (exit_req) begin m_exit = 1; m_mode = 2; end
               else if (preempt) m_mode = 2;
            2: begin
                if (exit_req) m_exit = 1;
                if (cpu_halted) begin m_mode = 3; m_step = 0; end
            end
            default: begin
                if (m_step == 0) begin
                    if (m_exit) begin m_valid[m_cur] = 0; m_n--; m_exit = 0; end
                    else m_pc[m_cur] = cpu_pc;
                    m_step = 1;
                end else if (m_step == 1) begin
                    found = 0;
                    for (int k = 1; k <= NPROC; k++) begin
                        idx = (m_cur + k) % NPROC;
                        if (!found && m_valid[idx]) begin
                            found = 1; m_cur = idx; m_lpc = m_pc[idx];
                        end
                    end
                    if (found) m_step = 2; else m_mode = 0;
                end else begin
                    m_mode = 1;
                end
            end
        endcase
        if (acc) begin
            found = 0;
            for (int i = 0; i < NPROC; i++) begin
                if (!found && !m_valid[i]) begin
                    found = 1; m_valid[i] = 1; m_pc[i] = create_pc;
                end
            end
            m_n++;
        end
    endtask

    // Compare process: advance the model at each edge, compare just after it.
    initial begin
        model_reset();
        forever begin
            @(posedge clock);
            if (reset) model_reset();
            else model_step();
            #1;
            if (check_en && !reset) begin
                if (load_pc_valid) strobe_cnt++;
                check("cycle_halt_req", cpu_halt_req, m_mode != 1);
                check("cycle_load_pc_valid", load_pc_valid, m_mode == 3 && m_step == 2);
                check("cycle_create_ready", create_ready, exp_cr());
                check("cycle_nprocs", nprocs, m_n);
                check("cycle_cur_pid", cur_pid, m_cur);
                check("cycle_load_pc", load_pc, m_lpc);
            end
        end
    end

    task automatic tick(); @(negedge clock); endtask

    task automatic do_create(input logic [PCW-1:0] pc);
        create_valid = 1'b1; create_pc = pc;
        tick();
        create_valid = 1'b0;
    endtask

    task automatic pulse(input bit p, input bit e);
        preempt = p; exit_req = e;
        tick();
        preempt = 1'b0; exit_req = 1'b0;
    endtask

    task automatic wait_run();
        int n;
        n = 0;
        while (cpu_halt_req !== 1'b0 && n < 50) begin tick(); n++; end
        if (n >= 50) check("wait_run_timeout", 1, 0);
    endtask

    task automatic switch_only(input logic [PCW-1:0] pc_at_halt);
        cpu_pc = pc_at_halt;
        pulse(1, 0);
        wait_run();
    endtask

    // Preempt with cpu_halted tied high: LOAD three edges after the halt request.
    task automatic switch_checked(input logic [PCW-1:0] pc_at_halt, input int pid, input logic [PCW-1:0] lpc);
        cpu_pc = pc_at_halt;
        pulse(1, 0);
        check("sw_halt_req", cpu_halt_req, 1);
        tick(); tick(); tick();
        check("sw_strobe", load_pc_valid, 1);
        check("sw_load_pc", load_pc, lpc);
        check("sw_cur_pid", cur_pid, pid);
        tick();
        check("sw_run", cpu_halt_req, 0);
        check("sw_strobe_gone", load_pc_valid, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #20;
        @(negedge clock);
        reset = 1'b0;
        check_en = 1'b1;
        check("rst_create_ready", create_ready, 1);
        check("rst_nprocs", nprocs, 0);
        check("rst_cur_pid", cur_pid, 0);
        check("rst_halt_req", cpu_halt_req, 1);
        check("rst_load_pc_valid", load_pc_valid, 0);
        check("rst_load_pc", load_pc, 0);

        // First process from IDLE
        do_create(32'h100);
        check("s1_nprocs", nprocs, 1);
        tick();
        check("s1_strobe", load_pc_valid, 1);
        check("s1_load_pc", load_pc, 32'h100);
        check("s1_cur_pid", cur_pid, 0);
        tick();
        check("s1_run", cpu_halt_req, 0);

        // Round-robin over three processes
        do_create(32'h200);
        do_create(32'h300);
        check("s2_nprocs", nprocs, 3);
        switch_checked(32'h140, 1, 32'h200);
        switch_checked(32'h2a0, 2, 32'h300);
        switch_checked(32'h3a0, 0, 32'h140);

        // Slow halt with a stray preempt during the wait
        strobe_cnt = 0;
        cpu_halted = 1'b0;
        cpu_pc = 32'h180;
        pulse(1, 0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) pulse(1, 0); else tick();
            check("s3_halt_held", cpu_halt_req, 1);
            check("s3_no_strobe", load_pc_valid, 0);
        end
        cpu_halted = 1'b1;
        wait_run();
        check("s3_strobes", strobe_cnt, 1);
        check("s3_cur_pid", cur_pid, 1);
        check("s3_load_pc", load_pc, 32'h2a0);

        // Exit wins over simultaneous preempt
        cpu_pc = 32'h1a1;
        pulse(1, 1);
        wait_run();
        check("s4_nprocs", nprocs, 2);
        check("s4_cur_pid", cur_pid, 2);
        check("s4_load_pc", load_pc, 32'h3a0);
        pulse(0, 1);
        wait_run();
        check("s4_nprocs_b", nprocs, 1);
        check("s4_cur_pid_b", cur_pid, 0);
        check("s4_load_pc_b", load_pc, 32'h180);
        strobe_cnt = 0;
        pulse(0, 1);
        for (int i = 0; i < 8; i++) tick();
        check("s4_idle_nprocs", nprocs, 0);
        check("s4_idle_halt", cpu_halt_req, 1);
        check("s4_idle_strobes", strobe_cnt, 0);

        // Fill every slot, reject while full, reuse a freed slot
        for (int i = 0; i < NPROC; i++) do_create(32'h1000 + 32'(i) * 32'h10);
        check("s5_full_nprocs", nprocs, 8);
        check("s5_full_ready", create_ready, 0);
        do_create(32'hdead);
        check("s5_reject_nprocs", nprocs, 8);
        for (int i = 0; i < 3; i++) switch_only(32'h5000 + 32'(i));
        check("s5_pid3", cur_pid, 3);
        pulse(0, 1);
        wait_run();
        check("s5_exit_nprocs", nprocs, 7);
        check("s5_exit_next", cur_pid, 4);
        check("s5_exit_load", load_pc, 32'h1040);
        do_create(32'habc);
        check("s5_refill_nprocs", nprocs, 8);
        for (int i = 0; i < 7; i++) switch_only(32'h6000 + 32'(i));
        check("s5_reuse_pid", cur_pid, 3);
        check("s5_reuse_pc", load_pc, 32'habc);

        // Asynchronous reset while in SAVE
        pulse(1, 0);
        tick();
        check("s6_in_save_ready", create_ready, 0);
        check("s6_in_save_halt", cpu_halt_req, 1);
        strobe_cnt = 0;
        reset = 1'b1;
        #1;
        check("s6_async_nprocs", nprocs, 0);
        check("s6_async_cur_pid", cur_pid, 0);
        check("s6_async_ready", create_ready, 1);
        check("s6_async_halt", cpu_halt_req, 1);
        check("s6_async_strobe", load_pc_valid, 0);
        check("s6_async_load_pc", load_pc, 0);
        @(negedge clock);
        reset = 1'b0;
        tick(); tick();
        check("s6_after_nprocs", nprocs, 0);
        check("s6_after_strobes", strobe_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
